// File: rtl/hgate_axi_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// Optional bus-wait timeout enabled by defining HGATE_AXIM_TIMEOUT_EN.
module hgate_axi_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP
    } state_t;

    state_t state, state_nx;

    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]                 wstrb_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    resp_q;
    logic                          aw_done, w_done;

    logic accept, busy, tmo;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign busy = (state == S_WRITE) || (state == S_WRESP) ||
                  (state == S_RADDR) || (state == S_RDATA);

`ifdef HGATE_AXIM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt, cnt_nx;
    logic          to_q;

    assign tmo = busy && (cnt == T_MAX);

    // Any progress on the bus or a state change restarts the wait window
    always_comb begin
        cnt_nx = cnt;
        if ((state_nx != state) || aw_hs || w_hs || b_hs || ar_hs || r_hs)
            cnt_nx = '0;
        else if (busy && (cnt != T_MAX))
            cnt_nx = cnt + 1'b1;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            cnt  <= '0;
            to_q <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (tmo)
                to_q <= 1'b1;
            else if (b_hs || r_hs)
                to_q <= 1'b0;
        end
    end

    assign rsp_timeout = to_q;
`else
    assign tmo         = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE) && !M_AXI_ARESET;
    assign accept    = cmd_valid && cmd_ready;

    assign M_AXI_AWVALID = (state == S_WRITE) && !aw_done && !tmo;
    assign M_AXI_WVALID  = (state == S_WRITE) && !w_done && !tmo;
    assign M_AXI_BREADY  = (state == S_WRESP) && !tmo;
    assign M_AXI_ARVALID = (state == S_RADDR) && !tmo;
    assign M_AXI_RREADY  = (state == S_RDATA) && !tmo;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

    assign rsp_valid = (state == S_RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (accept)
                    state_nx = cmd_we ? S_WRITE : S_RADDR;
            S_WRITE:
                if (tmo)
                    state_nx = S_RSP;
                else if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nx = S_WRESP;
            S_WRESP:
                if (tmo || b_hs)
                    state_nx = S_RSP;
            S_RADDR:
                if (tmo)
                    state_nx = S_RSP;
                else if (ar_hs)
                    state_nx = S_RDATA;
            S_RDATA:
                if (tmo || r_hs)
                    state_nx = S_RSP;
            S_RSP:
                if (rsp_ready)
                    state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs)
                aw_done <= 1'b1;
            if (w_hs)
                w_done <= 1'b1;
            if (b_hs) begin
                resp_q  <= M_AXI_BRESP;
                rdata_q <= '0;
            end
            if (r_hs) begin
                resp_q  <= M_AXI_RRESP;
                rdata_q <= M_AXI_RDATA;
            end
            if (tmo) begin
                resp_q  <= 2'b11;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: doc/hgate_axi_master.md
HGATE_AXI_MASTER -- requirements
Module: hgate_axi_master

Interface
REQ-001 C_M_AXI_ADDR_WIDTH, 8, address width.
REQ-002 C_M_AXI_DATA_WIDTH, 32, data width; WSTRB width is C_M_AXI_DATA_WIDTH/8.
REQ-003 TIMEOUT_CYCLES, 255, bus-wait limit; used only with the timeout feature (REQ-043).
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 M_AXI_ACLK  in  1  the single clock.
REQ-006 M_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-009 cmd_we  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data.
REQ-012 cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  response consumed.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
REQ-016 rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout.
REQ-017 rsp_timeout  out  1  response produced by timeout.
REQ-018 M_AXI_AWADDR/AWVALID out, AWREADY in  write address channel.
REQ-019 M_AXI_WDATA/WSTRB/WVALID out, WREADY in  write data channel.
REQ-020 M_AXI_BRESP/BVALID in, BREADY out  write response channel.
REQ-021 M_AXI_ARADDR/ARVALID out, ARREADY in  read address channel.
REQ-022 M_AXI_RDATA/RRESP/RVALID in, RREADY out  read data channel.

Function
REQ-023 States SHALL be IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
REQ-024 cmd_ready SHALL be 1 only in IDLE; on acceptance, command fields are registered.
REQ-025 An accepted write SHALL go to WRITE next cycle, driving AWVALID and WVALID together.
REQ-026 AWVALID and WVALID SHALL each drop independently on their own handshake; WRITE exits to WRESP once both handshakes have occurred, in either order or the same cycle.
REQ-027 A valid SHALL never be deasserted before its handshake, except on timeout (REQ-043).
REQ-028 Address, data and strobe outputs SHALL stay stable while their VALID is high.
REQ-029 In WRESP, BREADY SHALL be 1; on BVALID, BRESP is captured, rsp_rdata=0, and the FSM goes to RSP.
REQ-030 An accepted read SHALL go to RADDR, driving ARVALID until ARREADY, then RDATA.
REQ-031 In RDATA, RREADY SHALL be 1; on RVALID, RDATA and RRESP are captured, and the FSM goes to RSP.
REQ-032 RREADY and BREADY SHALL be 0 outside RDATA and WRESP respectively.
REQ-033 In RSP, rsp_valid SHALL be 1 with fields stable until rsp_ready, then return to IDLE.
REQ-034 Only one transaction SHALL be outstanding at a time.
REQ-035 Minimum latency, cmd accept to rsp_valid, SHALL be 3 cycles with zero-wait slave (accept, AW/W, B).
REQ-036 rsp_resp SHALL pass SLVERR/DECERR through unmodified, with rsp_timeout=0.

Reset
REQ-037 Reset SHALL force IDLE asynchronously, including mid-transaction with valids pending.
REQ-038 All VALID/READY outputs, rsp_* outputs and the wait counter SHALL reset to 0; cmd_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-039 The timeout feature SHALL be controlled by macro HGATE_AXIM_TIMEOUT_EN.
REQ-040 When defined, a counter SHALL clear on every state entry and every channel handshake, and increment each cycle in WRITE, WRESP, RADDR or RDATA.
REQ-041 The counter SHALL saturate at TIMEOUT_CYCLES.
REQ-042 When the counter reaches TIMEOUT_CYCLES, all bus VALID/READY outputs SHALL drop.
REQ-043 On that timeout, the FSM SHALL enter RSP with rsp_resp=2'b11, rsp_rdata=0 and rsp_timeout=1.
REQ-044 When undefined, no counter SHALL be built, rsp_timeout SHALL be tied 0, and the FSM waits indefinitely.

Verification
REQ-045 Write 0x10 <= 0xDEADBEEF, strobe 0xF, zero-wait slave -> AW/W in the same cycle, rsp_valid at cycle 3, resp 00.
REQ-046 Write with AWREADY delayed 4 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles, one response.
REQ-047 Read 0x20, slave returns 0x12345678 with RRESP 10 after 2 wait cycles -> rsp_rdata 0x12345678, rsp_resp 10.
REQ-048 rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready.
REQ-049 With HGATE_AXIM_TIMEOUT_EN and TIMEOUT_CYCLES=8, ARREADY never asserted -> ARVALID drops, rsp_resp 11, rsp_timeout 1.
REQ-050 Reset asserted while in WRESP -> all outputs 0 immediately and cmd_ready=1 after release.
